// File: rtl/net_pkg.sv
// Shared types for the net pin collector: default field widths, the pin
// record held per buffered pin, and the collector state encoding.
package net_pkg;

  localparam int NET_W     = 16;
  localparam int INST_W    = 16;
  localparam int PIN_W     = 4;
  localparam int MAX_SINKS = 7;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PIN_W-1:0]  pin;
    logic              drv;
  } pin_rec_t;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } npc_state_e;

endpackage

// File: rtl/npc_sink_buf.sv
// Sink buffer for one net: MAX_SINKS pin records, written in arrival order
// and read back in the same order. clr_i rewinds both pointers and the count
// and takes priority over a same-cycle write or read advance.
module npc_sink_buf #(
  parameter int MAX_SINKS = net_pkg::MAX_SINKS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_i,
  input  logic                             wr_en_i,
  input  net_pkg::pin_rec_t                wr_data_i,
  input  logic                             rd_adv_i,
  output net_pkg::pin_rec_t                rd_data_o,
  output logic                             rd_last_o,
  output logic [$clog2(MAX_SINKS+1)-1:0]   count_o,
  output logic                             full_o
);
  import net_pkg::*;

  localparam int CW = $clog2(MAX_SINKS + 1);

  pin_rec_t      mem_q [MAX_SINKS];
  logic [CW-1:0] wr_ptr_q, rd_ptr_q, count_q;
  logic          wr_go;

  assign full_o    = (count_q == CW'(MAX_SINKS));
  assign wr_go     = wr_en_i && !full_o;
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign rd_last_o = ((rd_ptr_q + CW'(1)) == count_q);

  // Storage array; contents are only observed below the count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Write/read pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr_q <= wr_ptr_q + CW'(1);
        count_q  <= count_q + CW'(1);
      end
      if (rd_adv_i) rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

endmodule

// File: rtl/net_pin_collector.sv
// Collects a flat pin stream into per-net records and re-emits each legal net
// driver-first with its sink count. Nets with no driver, several drivers or
// too many sinks are discarded with a one-cycle net_drop pulse.
// Optional build macro NET_PIN_COLLECTOR_NET_CHECK_EN: compare in_net of every
// later beat against the net id latched from the first beat; a mismatch
// discards the net and sets the sticky err_net_mismatch output.
//
// state   | meaning
// COLLECT | accepting pins of the current net into driver reg / sink buffer
// EMIT    | replaying driver then sinks downstream, input stalled
module net_pin_collector #(
  parameter int NET_W     = net_pkg::NET_W,
  parameter int INST_W    = net_pkg::INST_W,
  parameter int PIN_W     = net_pkg::PIN_W,
  parameter int MAX_SINKS = net_pkg::MAX_SINKS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NET_W-1:0]               in_net,
  input  logic [INST_W-1:0]              in_inst,
  input  logic [PIN_W-1:0]               in_pin,
  input  logic                           in_drv,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NET_W-1:0]               out_net,
  output logic [INST_W-1:0]              out_inst,
  output logic [PIN_W-1:0]               out_pin,
  output logic                           out_drv,
  output logic                           out_first,
  output logic                           out_last,
  output logic [$clog2(MAX_SINKS+1)-1:0] out_fanout,
  output logic                           net_drop,
  input  logic                           err_clr,
  output logic                           err_no_drv,
  output logic                           err_multi_drv,
`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
  output logic                           err_overflow,
  output logic                           err_net_mismatch
`else
  output logic                           err_overflow
`endif
);
  import net_pkg::*;

  localparam int CW = $clog2(MAX_SINKS + 1);

  npc_state_e       state_q, state_d;
  pin_rec_t         drv_rec_q, drv_rec_d, in_rec, buf_rd;
  logic [NET_W-1:0] net_q, net_d;
  logic             have_drv_q, have_drv_d, bad_q, bad_d;
  logic             started_q, started_d, drv_phase_q, drv_phase_d;
  logic             net_drop_q, net_drop_d;
  logic             err_nd_q, err_nd_d, err_md_q, err_md_d, err_ov_q, err_ov_d;
  logic             set_nd, set_md, set_ov, set_mis;
  logic             buf_clr, buf_wr, buf_rd_adv, buf_rd_last, buf_full;
  logic [CW-1:0]    buf_count;
  logic             emitting;

  assign in_rec = '{inst: in_inst, pin: in_pin, drv: in_drv};

  npc_sink_buf #(.MAX_SINKS(MAX_SINKS)) u_sink_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_data_i (in_rec),
    .rd_adv_i  (buf_rd_adv),
    .rd_data_o (buf_rd),
    .rd_last_o (buf_rd_last),
    .count_o   (buf_count),
    .full_o    (buf_full)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next state, per-net bookkeeping and error set conditions.
  always_comb begin
    state_d     = state_q;
    drv_rec_d   = drv_rec_q;
    net_d       = net_q;
    have_drv_d  = have_drv_q;
    bad_d       = bad_q;
    started_d   = started_q;
    drv_phase_d = drv_phase_q;
    net_drop_d  = 1'b0;
    buf_clr     = 1'b0;
    buf_wr      = 1'b0;
    buf_rd_adv  = 1'b0;
    set_nd      = 1'b0;
    set_md      = 1'b0;
    set_ov      = 1'b0;
    set_mis     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (!started_q) begin
            net_d     = in_net;
            started_d = 1'b1;
          end
`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
          else if (in_net != net_q) set_mis = 1'b1;
`endif
          if (in_drv) begin
            if (have_drv_q) set_md = 1'b1;
            else begin
              drv_rec_d  = in_rec;
              have_drv_d = 1'b1;
            end
          end else if (buf_full) set_ov = 1'b1;
          else buf_wr = 1'b1;
          bad_d = bad_q | set_md | set_ov | set_mis;
          if (in_last) begin
            if (bad_d || !have_drv_d) begin
              set_nd     = !have_drv_d;
              net_drop_d = 1'b1;
              buf_clr    = 1'b1;
              have_drv_d = 1'b0;
              bad_d      = 1'b0;
              started_d  = 1'b0;
            end else begin
              state_d = EMIT;
            end
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if ((drv_phase_q && buf_count == '0) || (!drv_phase_q && buf_rd_last)) begin
            state_d     = COLLECT;
            buf_clr     = 1'b1;
            have_drv_d  = 1'b0;
            bad_d       = 1'b0;
            started_d   = 1'b0;
            drv_phase_d = 1'b1;
          end else if (drv_phase_q) begin
            drv_phase_d = 1'b0;
          end else begin
            buf_rd_adv = 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    // A same-cycle set beats err_clr.
    err_nd_d = (err_nd_q & ~err_clr) | set_nd;
    err_md_d = (err_md_q & ~err_clr) | set_md;
    err_ov_d = (err_ov_q & ~err_clr) | set_ov;
  end

  // Per-net registers, drop pulse and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_rec_q   <= '0;
      net_q       <= '0;
      have_drv_q  <= 1'b0;
      bad_q       <= 1'b0;
      started_q   <= 1'b0;
      drv_phase_q <= 1'b1;
      net_drop_q  <= 1'b0;
      err_nd_q    <= 1'b0;
      err_md_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      drv_rec_q   <= drv_rec_d;
      net_q       <= net_d;
      have_drv_q  <= have_drv_d;
      bad_q       <= bad_d;
      started_q   <= started_d;
      drv_phase_q <= drv_phase_d;
      net_drop_q  <= net_drop_d;
      err_nd_q    <= err_nd_d;
      err_md_q    <= err_md_d;
      err_ov_q    <= err_ov_d;
    end
  end

`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
  logic err_mis_q, err_mis_d;
  assign err_mis_d        = (err_mis_q & ~err_clr) | set_mis;
  assign err_net_mismatch = err_mis_q;

  // Sticky net-id mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_mis_q <= 1'b0;
    else        err_mis_q <= err_mis_d;
  end
`endif

  assign emitting      = (state_q == EMIT);
  assign in_ready      = !emitting;
  assign out_valid     = emitting;
  assign net_drop      = net_drop_q;
  assign err_no_drv    = err_nd_q;
  assign err_multi_drv = err_md_q;
  assign err_overflow  = err_ov_q;

  // Output beat: driver register on the first beat, sink buffer after; zero when idle.
  always_comb begin
    out_net    = '0;
    out_inst   = '0;
    out_pin    = '0;
    out_drv    = 1'b0;
    out_first  = 1'b0;
    out_last   = 1'b0;
    out_fanout = '0;
    if (emitting) begin
      out_net    = net_q;
      out_first  = drv_phase_q;
      out_fanout = buf_count;
      if (drv_phase_q) begin
        out_inst = drv_rec_q.inst;
        out_pin  = drv_rec_q.pin;
        out_drv  = drv_rec_q.drv;
        out_last = (buf_count == '0);
      end else begin
        out_inst = buf_rd.inst;
        out_pin  = buf_rd.pin;
        out_drv  = buf_rd.drv;
        out_last = buf_rd_last;
      end
    end
  end

endmodule

// File: tb/tb_net_pin_collector.sv
// Randomized bench for net_pin_collector with a per-net reference model:
// each net's pins are gathered whole, judged at in_last, and the expected
// output beats are queued driver-first. Build with
// NET_PIN_COLLECTOR_NET_CHECK_EN to exercise the net-id check.
module tb_net_pin_collector;

  localparam int MAXS = 7;
  localparam int FW   = 3;
`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
  localparam bit NET_CHK = 1'b1;
`else
  localparam bit NET_CHK = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [15:0]   in_net = '0, in_inst = '0;
  logic [3:0]    in_pin = '0;
  logic          in_drv = 1'b0, in_last = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [15:0]   out_net, out_inst;
  logic [3:0]    out_pin;
  logic          out_drv, out_first, out_last;
  logic [FW-1:0] out_fanout;
  logic          net_drop, err_clr = 1'b0;
  logic          err_no_drv, err_multi_drv, err_overflow;
`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
  logic          err_net_mismatch;
`endif

  net_pin_collector dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_net(in_net), .in_inst(in_inst),
    .in_pin(in_pin), .in_drv(in_drv), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_net(out_net), .out_inst(out_inst),
    .out_pin(out_pin), .out_drv(out_drv), .out_first(out_first), .out_last(out_last),
    .out_fanout(out_fanout), .net_drop(net_drop), .err_clr(err_clr),
    .err_no_drv(err_no_drv), .err_multi_drv(err_multi_drv),
`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
    .err_overflow(err_overflow), .err_net_mismatch(err_net_mismatch)
`else
    .err_overflow(err_overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   net, inst;
    logic [3:0]    pin;
    logic          drv, first, last;
    logic [FW-1:0] fanout;
  } beat_t;

  int checks = 0, errors = 0;

  // model state
  beat_t       exp_q[$];
  beat_t       cur_sinks[$];
  beat_t       cur_drv;
  logic [15:0] cur_net;
  bit          cur_started, cur_bad;
  int          cur_ndrv, cur_nsink;
  bit          e_nd, e_md, e_ov, e_mis, exp_drop;
  bit          s_nd, s_md, s_ov, s_mis;

  // stimulus state
  logic        v_valid = 0, v_drv = 0, v_last = 0, v_clr = 0;
  logic [15:0] v_net = 0, v_inst = 0;
  logic [3:0]  v_pin = 0;
  bit          rnd_rdy = 0, rnd_clr = 0, acc_in, acc_out;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    cur_sinks.delete();
    cur_started = 0; cur_bad = 0; cur_ndrv = 0; cur_nsink = 0;
    e_nd = 0; e_md = 0; e_ov = 0; e_mis = 0; exp_drop = 0;
  endfunction

  function automatic void model_accept();
    beat_t b;
    if (!cur_started) begin
      cur_started = 1; cur_net = in_net;
    end else if (NET_CHK && in_net != cur_net) begin
      s_mis = 1; cur_bad = 1;
    end
    b = '{net: cur_net, inst: in_inst, pin: in_pin, drv: in_drv, first: 0, last: 0, fanout: 0};
    if (in_drv) begin
      if (cur_ndrv > 0) begin s_md = 1; cur_bad = 1; end
      else cur_drv = b;
      cur_ndrv++;
    end else begin
      if (cur_nsink >= MAXS) begin s_ov = 1; cur_bad = 1; end
      else cur_sinks.push_back(b);
      cur_nsink++;
    end
    if (in_last) begin
      if (cur_ndrv == 0) s_nd = 1;
      if (cur_bad || cur_ndrv == 0) exp_drop = 1;
      else begin
        cur_drv.first  = 1;
        cur_drv.fanout = FW'(cur_sinks.size());
        cur_drv.last   = (cur_sinks.size() == 0);
        exp_q.push_back(cur_drv);
        for (int i = 0; i < cur_sinks.size(); i++) begin
          b = cur_sinks[i];
          b.last = (i == cur_sinks.size() - 1);
          exp_q.push_back(b);
        end
      end
      cur_sinks.delete();
      cur_started = 0; cur_bad = 0; cur_ndrv = 0; cur_nsink = 0;
    end
  endfunction

  function automatic void check();
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_net", 32'(out_net), 32'(exp_q[0].net));
      chk("out_inst", 32'(out_inst), 32'(exp_q[0].inst));
      chk("out_pin", 32'(out_pin), 32'(exp_q[0].pin));
      chk("out_drv", 32'(out_drv), 32'(exp_q[0].drv));
      chk("out_first", 32'(out_first), 32'(exp_q[0].first));
      chk("out_last", 32'(out_last), 32'(exp_q[0].last));
      if (exp_q[0].first) chk("out_fanout", 32'(out_fanout), 32'(exp_q[0].fanout));
    end
    chk("net_drop", 32'(net_drop), 32'(exp_drop));
    chk("err_no_drv", 32'(err_no_drv), 32'(e_nd));
    chk("err_multi_drv", 32'(err_multi_drv), 32'(e_md));
    chk("err_overflow", 32'(err_overflow), 32'(e_ov));
`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
    chk("err_net_mismatch", 32'(err_net_mismatch), 32'(e_mis));
`endif
  endfunction

  // One clock: drive at the falling edge, predict the rising edge, check at the next falling edge.
  task automatic cycle();
    in_valid = v_valid; in_net = v_net; in_inst = v_inst; in_pin = v_pin;
    in_drv = v_drv; in_last = v_last;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    err_clr = rnd_clr ? ($urandom_range(0, 15) == 0) : v_clr;
    #1;
    acc_in = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    s_nd = 0; s_md = 0; s_ov = 0; s_mis = 0; exp_drop = 0;
    if (acc_out && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc_in) model_accept();
    e_nd  = (e_nd  & !err_clr) | s_nd;
    e_md  = (e_md  & !err_clr) | s_md;
    e_ov  = (e_ov  & !err_clr) | s_ov;
    e_mis = (e_mis & !err_clr) | s_mis;
    @(negedge clk);
    check();
  endtask

  task automatic send_beat(input logic [15:0] n, input logic [15:0] inst,
                           input logic [3:0] p, input logic d, input logic l);
    int  budget = 200;
    bit  done = 0;
    if ($urandom_range(0, 3) == 0) cycle();
    v_valid = 1; v_net = n; v_inst = inst; v_pin = p; v_drv = d; v_last = l;
    while (!done && budget > 0) begin
      cycle();
      done = acc_in;
      budget--;
    end
    v_valid = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat not accepted, got 0 expected 1");
    end
  endtask

  task automatic drain();
    int budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; v_valid = 0; out_ready = 0; err_clr = 0; v_clr = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", {out_inst, out_net}, 32'd0);
    chk("rst_out_misc", {24'd0, out_pin, out_drv, out_first, out_last, 1'b0}, 32'd0);
    chk("rst_fanout", 32'(out_fanout), 32'd0);
    chk("rst_drop_err", {28'd0, net_drop, err_no_drv, err_multi_drv, err_overflow}, 32'd0);
  endtask

  task automatic rand_net(input logic [15:0] n);
    bit isd[$];
    int nd, ns, tot, r;
    r  = $urandom_range(0, 9);
    nd = (r == 0) ? 0 : (r == 1) ? 2 : 1;
    ns = $urandom_range(0, 8);
    if (nd == 0 && ns == 0) ns = 1;
    for (int i = 0; i < ns; i++) isd.push_back(1'b0);
    for (int j = 0; j < nd; j++) isd.insert($urandom_range(0, isd.size()), 1'b1);
    tot = nd + ns;
    for (int i = 0; i < tot; i++)
      send_beat(n, 16'($urandom), 4'($urandom), isd[i], i == tot - 1);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // net 5: driver then two sinks
    send_beat(16'd5, 16'd10, 4'd0, 1'b1, 1'b0);
    send_beat(16'd5, 16'd11, 4'd1, 1'b0, 1'b0);
    send_beat(16'd5, 16'd12, 4'd2, 1'b0, 1'b1);
    chk("lit_n5_beats", 32'(exp_q.size()), 32'd3);
    chk("lit_n5_drv_inst", 32'(exp_q[0].inst), 32'd10);
    chk("lit_n5_fanout", 32'(exp_q[0].fanout), 32'd2);
    chk("lit_n5_tail", {exp_q[2].inst, 15'd0, exp_q[2].last}, {16'd12, 15'd0, 1'b1});
    drain();

    // sinks before the driver
    send_beat(16'd6, 16'd20, 4'd1, 1'b0, 1'b0);
    send_beat(16'd6, 16'd21, 4'd0, 1'b1, 1'b0);
    send_beat(16'd6, 16'd22, 4'd3, 1'b0, 1'b1);
    chk("lit_n6_order", {exp_q[0].inst, exp_q[1].inst}, {16'd21, 16'd20});
    drain();

    // driver-only net
    send_beat(16'd7, 16'd30, 4'd0, 1'b1, 1'b1);
    chk("lit_n7_single", {29'd0, exp_q[0].first, exp_q[0].last, 1'(exp_q.size() == 1)}, 32'd7);
    drain();

    // two drivers, then no driver
    send_beat(16'd8, 16'd40, 4'd0, 1'b1, 1'b0);
    send_beat(16'd8, 16'd41, 4'd0, 1'b1, 1'b0);
    send_beat(16'd8, 16'd42, 4'd1, 1'b0, 1'b1);
    send_beat(16'd9, 16'd50, 4'd1, 1'b0, 1'b0);
    send_beat(16'd9, 16'd51, 4'd2, 1'b0, 1'b1);
    chk("lit_drop_errs", {30'd0, e_md, e_nd}, 32'd3);
    chk("lit_drop_noout", 32'(exp_q.size()), 32'd0);
    v_clr = 1; cycle(); v_clr = 0;
    chk("lit_clr_errs", {30'd0, e_md, e_nd}, 32'd0);
    cycle();

    // overflow, then a legal net
    send_beat(16'd10, 16'd60, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_beat(16'd10, 16'(61 + i), 4'(i), 1'b0, i == 7);
    chk("lit_ovf", {30'd0, e_ov, 1'(exp_q.size() == 0)}, 32'd3);
    send_beat(16'd11, 16'd70, 4'd0, 1'b1, 1'b0);
    send_beat(16'd11, 16'd71, 4'd1, 1'b0, 1'b1);
    drain();

`ifdef NET_PIN_COLLECTOR_NET_CHECK_EN
    send_beat(16'd13, 16'd80, 4'd0, 1'b1, 1'b0);
    send_beat(16'd14, 16'd81, 4'd1, 1'b0, 1'b0);
    send_beat(16'd13, 16'd82, 4'd2, 1'b0, 1'b1);
    chk("lit_mismatch", {30'd0, e_mis, 1'(exp_q.size() == 0)}, 32'd3);
    cycle();
`endif

    // full 7-sink net with random backpressure
    rnd_rdy = 1;
    send_beat(16'd12, 16'd90, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_beat(16'd12, 16'(91 + i), 4'(i), 1'b0, i == 6);
    chk("lit_7sink_beats", 32'(exp_q.size()), 32'd8);
    drain();

    // reset mid-collect, then mid-emit
    rnd_rdy = 0;
    send_beat(16'd15, 16'd100, 4'd0, 1'b1, 1'b0);
    send_beat(16'd15, 16'd101, 4'd1, 1'b0, 1'b0);
    do_reset();
    cycle();
    send_beat(16'd16, 16'd110, 4'd0, 1'b1, 1'b0);
    send_beat(16'd16, 16'd111, 4'd1, 1'b0, 1'b0);
    send_beat(16'd16, 16'd112, 4'd2, 1'b0, 1'b1);
    cycle();
    do_reset();
    cycle();

    // random nets, backpressure and error clears
    rnd_rdy = 1; rnd_clr = 1;
    for (int n = 0; n < 40; n++) rand_net(16'($urandom));
    rnd_clr = 0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
